// File: rtl/apb_pkg.sv
// Shared APB completer types: FSM states, error-cause encodings, region permission decode.
// Pure declarations, no latency or flow control of its own.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ABORT
    } apb_cmp_state_e;

    // One-hot error causes; the completer ORs them into a cause vector.
    localparam logic [3:0] ERR_UNALIGNED = 4'b0001;
    localparam logic [3:0] ERR_RANGE     = 4'b0010;
    localparam logic [3:0] ERR_PROT      = 4'b0100;
    localparam logic [3:0] ERR_RO        = 4'b1000;

    function automatic logic [2:0] req_pprot(input logic [63:0] addr, input int unsigned region_lsb);
        return addr[region_lsb +: 3];
    endfunction

endpackage

// File: rtl/apb_completer_regfile.sv
// Byte-strobed register file: one synchronous write port, combinational read.
// Word 0 is a read-only ID constant; writes to it are dropped.
module apb_completer_regfile #(
    parameter int unsigned             DATA_WIDTH = 32,
    parameter int unsigned             NUM_REGS   = 16,
    parameter logic [DATA_WIDTH-1:0]   ID_VALUE   = 32'hA9B0_0001,
    localparam int unsigned            IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    we_i,
    input  logic [IDX_W-1:0]        widx_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic [IDX_W-1:0]        ridx_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [1:NUM_REGS-1];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && widx_i != '0) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[widx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = (ridx_i == '0) ? ID_VALUE : mem_q[ridx_i];

endmodule

// File: rtl/apb_completer_regs.sv
// APB completer over a small register file with alignment/range/PPROT/read-only checks.
// pready rises WAIT_STATES cycles into ACCESS; dropping psel mid-transfer aborts with pslverr.
module apb_completer_regs
    import apb_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           NUM_REGS    = 16,
    parameter int unsigned           REGION_LSB  = 6,
    parameter int unsigned           WAIT_STATES = 1,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic                    pclk,
    input  logic                    reset,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic [2:0]              pprot,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);
    localparam int unsigned CNT_W = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);

    apb_cmp_state_e        state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  write_q;
    logic [3:0]            err_cause_q;
    logic                  pready_q;
    logic                  pslverr_q;
    logic [DATA_WIDTH-1:0] prdata_q;

    logic [IDX_W-1:0]      setup_idx;
    logic [2:0]            setup_req;
    logic [3:0]            setup_cause;
    logic [IDX_W-1:0]      cur_idx;
    logic                  cur_write;
    logic                  cur_err;
    logic [DATA_WIDTH-1:0] rf_rdata;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  commit;

    assign setup_idx = paddr[2 +: IDX_W];
    assign setup_req = req_pprot(64'(paddr), REGION_LSB);

    always_comb begin
        setup_cause = '0;
        if (paddr[1:0] != 2'b00)                setup_cause = setup_cause | ERR_UNALIGNED;
        if (|(paddr >> (REGION_LSB + 3)))       setup_cause = setup_cause | ERR_RANGE;
        if ((pprot & setup_req) != setup_req)   setup_cause = setup_cause | ERR_PROT;
        if (pwrite && setup_idx == '0)          setup_cause = setup_cause | ERR_RO;
    end

    // The read port follows the live setup address in IDLE so a zero-wait response is ready at once.
    assign cur_idx    = (state_q == IDLE) ? setup_idx : idx_q;
    assign cur_write  = (state_q == IDLE) ? pwrite : write_q;
    assign cur_err    = (state_q == IDLE) ? (|setup_cause) : (|err_cause_q);
    assign resp_rdata = (!cur_err && !cur_write) ? rf_rdata : '0;

    assign commit = (state_q == ACCESS) && psel && penable && pready_q && write_q && (err_cause_q == '0);

    apb_completer_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .ID_VALUE   (ID_VALUE)
    ) u_regfile (
        .clk_i   (pclk),
        .reset_i (reset),
        .we_i    (commit),
        .widx_i  (idx_q),
        .wdata_i (pwdata),
        .wstrb_i (pstrb),
        .ridx_i  (cur_idx),
        .rdata_o (rf_rdata)
    );

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            write_q     <= 1'b0;
            err_cause_q <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            prdata_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (psel && !penable) begin
                        state_q     <= ACCESS;
                        idx_q       <= setup_idx;
                        write_q     <= pwrite;
                        err_cause_q <= setup_cause;
                        cnt_q       <= CNT_W'(WAIT_STATES);
                        if (WAIT_STATES == 0) begin
                            pready_q  <= 1'b1;
                            pslverr_q <= |setup_cause;
                            prdata_q  <= resp_rdata;
                        end
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        state_q   <= ABORT;
                        pready_q  <= 1'b1;
                        pslverr_q <= 1'b1;
                        prdata_q  <= '0;
                    end else if (penable && pready_q) begin
                        state_q   <= IDLE;
                        pready_q  <= 1'b0;
                        pslverr_q <= 1'b0;
                        prdata_q  <= '0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            pready_q  <= 1'b1;
                            pslverr_q <= |err_cause_q;
                            prdata_q  <= resp_rdata;
                        end
                    end
                end
                ABORT: begin
                    if (!penable) begin
                        state_q   <= IDLE;
                        pready_q  <= 1'b0;
                        pslverr_q <= 1'b0;
                        prdata_q  <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_completer_regs.sv
// Self-checking bench for apb_completer_regs: scripted APB transfers against a response scoreboard.
module tb_apb_completer_regs;

    localparam int          WS = 3;
    localparam logic [31:0] ID = 32'hA9B0_0001;

    logic        pclk, reset, psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready, pslverr;

    apb_completer_regs #(
        .ADDR_WIDTH (32), .DATA_WIDTH (32), .NUM_REGS (16),
        .REGION_LSB (6), .WAIT_STATES (WS), .ID_VALUE (ID)
    ) dut (
        .pclk (pclk), .reset (reset), .psel (psel), .penable (penable), .pwrite (pwrite),
        .paddr (paddr), .pwdata (pwdata), .pstrb (pstrb), .pprot (pprot),
        .prdata (prdata), .pready (pready), .pslverr (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [2:0]  p;
        logic [31:0] exp_d;
        logic        exp_e;
    } xfer_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] obs_rdata;
    logic        obs_err;
    int          obs_waits;
    bit          obs_to;

    // Full transfer: setup, access until pready (bounded), completion edge; returns with psel low just after it.
    task automatic apb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [2:0] p);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s; pprot = p;
        @(negedge pclk);
        penable   = 1'b1;
        obs_waits = 0;
        while (pready !== 1'b1 && obs_waits < 64) begin
            @(negedge pclk);
            obs_waits++;
        end
        obs_to    = (pready !== 1'b1);
        obs_rdata = prdata;
        obs_err   = pslverr;
        @(posedge pclk);
        #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        xfer_t tbl[$];
        exp_t  ex;
        reset = 1'b1;
        repeat (3) @(negedge pclk);
        n_cmp++; if (pready !== 1'b0)   begin n_bad++; $display("FAIL reset_pready: got %b want 0", pready); end
        n_cmp++; if (pslverr !== 1'b0)  begin n_bad++; $display("FAIL reset_pslverr: got %b want 0", pslverr); end
        n_cmp++; if (prdata !== 32'h0)  begin n_bad++; $display("FAIL reset_prdata: got %h want 0", prdata); end
        reset = 1'b0;
        tbl.push_back('{1'b0, 32'h00, 32'h0, 4'h0, 3'b000, ID,    1'b0});
        tbl.push_back('{1'b0, 32'h3C, 32'h0, 4'h0, 3'b000, 32'h0, 1'b0});
        foreach (tbl[i]) begin
            sb.push_back('{tbl[i].exp_d, tbl[i].exp_e});
            apb_xfer(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].p);
            ex = sb.pop_front();
            n_cmp++; if (obs_to)             begin n_bad++; $display("FAIL reset_rd[%0d] timeout: no pready", i); end
            n_cmp++; if (obs_waits !== WS)   begin n_bad++; $display("FAIL reset_rd[%0d] waits: got %0d want %0d", i, obs_waits, WS); end
            n_cmp++; if (obs_err !== ex.err) begin n_bad++; $display("FAIL reset_rd[%0d] pslverr: got %b want %b", i, obs_err, ex.err); end
            n_cmp++; if (obs_rdata !== ex.rdata) begin n_bad++; $display("FAIL reset_rd[%0d] prdata: got %h want %h", i, obs_rdata, ex.rdata); end
        end
    endtask

    task automatic test_write_read();
        xfer_t tbl[$];
        exp_t  ex;
        tbl.push_back('{1'b1, 32'h04, 32'h1234_5678, 4'hF, 3'b000, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h04, 32'h0,         4'h0, 3'b000, 32'h1234_5678, 1'b0});
        tbl.push_back('{1'b1, 32'h08, 32'hFFFF_FFFF, 4'h5, 3'b000, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h08, 32'h0,         4'h0, 3'b000, 32'h00FF_00FF, 1'b0});
        tbl.push_back('{1'b1, 32'h08, 32'hAABB_CCDD, 4'hA, 3'b000, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h08, 32'h0,         4'h0, 3'b000, 32'hAAFF_CCFF, 1'b0});
        foreach (tbl[i]) begin
            sb.push_back('{tbl[i].exp_d, tbl[i].exp_e});
            apb_xfer(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].p);
            ex = sb.pop_front();
            n_cmp++; if (obs_to)             begin n_bad++; $display("FAIL wr_rd[%0d] timeout: no pready", i); end
            n_cmp++; if (obs_waits !== WS)   begin n_bad++; $display("FAIL wr_rd[%0d] waits: got %0d want %0d", i, obs_waits, WS); end
            n_cmp++; if (obs_err !== ex.err) begin n_bad++; $display("FAIL wr_rd[%0d] pslverr: got %b want %b", i, obs_err, ex.err); end
            n_cmp++; if (obs_rdata !== ex.rdata) begin n_bad++; $display("FAIL wr_rd[%0d] prdata: got %h want %h", i, obs_rdata, ex.rdata); end
        end
    endtask

    task automatic test_errors();
        xfer_t tbl[$];
        exp_t  ex;
        tbl.push_back('{1'b0, 32'h1C4, 32'h0,         4'h0, 3'b111, 32'h1234_5678, 1'b0});
        tbl.push_back('{1'b0, 32'h1C4, 32'h0,         4'h0, 3'b110, 32'h0, 1'b1});
        tbl.push_back('{1'b0, 32'h1C4, 32'h0,         4'h0, 3'b101, 32'h0, 1'b1});
        tbl.push_back('{1'b0, 32'h1C4, 32'h0,         4'h0, 3'b011, 32'h0, 1'b1});
        tbl.push_back('{1'b1, 32'h044, 32'hDEAD_0000, 4'hF, 3'b000, 32'h0, 1'b1});
        tbl.push_back('{1'b0, 32'h004, 32'h0,         4'h0, 3'b000, 32'h1234_5678, 1'b0});
        tbl.push_back('{1'b0, 32'h003, 32'h0,         4'h0, 3'b000, 32'h0, 1'b1});
        tbl.push_back('{1'b1, 32'h000, 32'h5555_5555, 4'hF, 3'b000, 32'h0, 1'b1});
        tbl.push_back('{1'b0, 32'h200, 32'h0,         4'h0, 3'b111, 32'h0, 1'b1});
        tbl.push_back('{1'b0, 32'h000, 32'h0,         4'h0, 3'b000, ID,    1'b0});
        foreach (tbl[i]) begin
            sb.push_back('{tbl[i].exp_d, tbl[i].exp_e});
            apb_xfer(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].p);
            ex = sb.pop_front();
            n_cmp++; if (obs_to)             begin n_bad++; $display("FAIL err[%0d] timeout: no pready", i); end
            n_cmp++; if (obs_waits !== WS)   begin n_bad++; $display("FAIL err[%0d] waits: got %0d want %0d", i, obs_waits, WS); end
            n_cmp++; if (obs_err !== ex.err) begin n_bad++; $display("FAIL err[%0d] pslverr: got %b want %b", i, obs_err, ex.err); end
            n_cmp++; if (obs_rdata !== ex.rdata) begin n_bad++; $display("FAIL err[%0d] prdata: got %h want %h", i, obs_rdata, ex.rdata); end
        end
    endtask

    task automatic test_back_to_back();
        xfer_t tbl[$];
        exp_t  ex;
        tbl.push_back('{1'b1, 32'h18, 32'h0BAD_CAFE, 4'hF, 3'b000, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h18, 32'h0,         4'h0, 3'b000, 32'h0BAD_CAFE, 1'b0});
        foreach (tbl[i]) begin
            sb.push_back('{tbl[i].exp_d, tbl[i].exp_e});
            apb_xfer(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].p);
            ex = sb.pop_front();
            n_cmp++; if (obs_to)             begin n_bad++; $display("FAIL b2b[%0d] timeout: no pready", i); end
            n_cmp++; if (obs_waits !== WS)   begin n_bad++; $display("FAIL b2b[%0d] waits: got %0d want %0d", i, obs_waits, WS); end
            n_cmp++; if (obs_err !== ex.err) begin n_bad++; $display("FAIL b2b[%0d] pslverr: got %b want %b", i, obs_err, ex.err); end
            n_cmp++; if (obs_rdata !== ex.rdata) begin n_bad++; $display("FAIL b2b[%0d] prdata: got %h want %h", i, obs_rdata, ex.rdata); end
        end
        // Requester lingers with psel&penable after completion: must not start a new transfer.
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; pwdata = 32'h7777_7777;
        for (int c = 0; c < 4; c++) begin
            @(negedge pclk);
            n_cmp++; if (pready !== 1'b0) begin n_bad++; $display("FAIL b2b_hold[%0d] pready: got %b want 0", c, pready); end
        end
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_abort();
        xfer_t tbl[$];
        exp_t  ex;
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'hDEAD_BEEF; pstrb = 4'hF; pprot = 3'b000;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge pclk);
            n_cmp++; if (pready !== 1'b1)  begin n_bad++; $display("FAIL abort[%0d] pready: got %b want 1", c, pready); end
            n_cmp++; if (pslverr !== 1'b1) begin n_bad++; $display("FAIL abort[%0d] pslverr: got %b want 1", c, pslverr); end
            n_cmp++; if (prdata !== 32'h0) begin n_bad++; $display("FAIL abort[%0d] prdata: got %h want 0", c, prdata); end
        end
        penable = 1'b0;
        @(negedge pclk);
        n_cmp++; if (pready !== 1'b0) begin n_bad++; $display("FAIL abort_exit pready: got %b want 0", pready); end
        tbl.push_back('{1'b0, 32'h0C, 32'h0, 4'h0, 3'b000, 32'h0, 1'b0});
        foreach (tbl[i]) begin
            sb.push_back('{tbl[i].exp_d, tbl[i].exp_e});
            apb_xfer(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].p);
            ex = sb.pop_front();
            n_cmp++; if (obs_to)             begin n_bad++; $display("FAIL abort_rd[%0d] timeout: no pready", i); end
            n_cmp++; if (obs_waits !== WS)   begin n_bad++; $display("FAIL abort_rd[%0d] waits: got %0d want %0d", i, obs_waits, WS); end
            n_cmp++; if (obs_err !== ex.err) begin n_bad++; $display("FAIL abort_rd[%0d] pslverr: got %b want %b", i, obs_err, ex.err); end
            n_cmp++; if (obs_rdata !== ex.rdata) begin n_bad++; $display("FAIL abort_rd[%0d] prdata: got %h want %h", i, obs_rdata, ex.rdata); end
        end
    endtask

    task automatic test_reset_mid();
        xfer_t tbl[$];
        exp_t  ex;
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hCAFE_F00D; pstrb = 4'hF; pprot = 3'b000;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        reset = 1'b1;
        @(negedge pclk);
        reset = 1'b0;
        n_cmp++; if (pready !== 1'b0)  begin n_bad++; $display("FAIL rstmid pready: got %b want 0", pready); end
        n_cmp++; if (pslverr !== 1'b0) begin n_bad++; $display("FAIL rstmid pslverr: got %b want 0", pslverr); end
        n_cmp++; if (prdata !== 32'h0) begin n_bad++; $display("FAIL rstmid prdata: got %h want 0", prdata); end
        // Bus still held in access phase: the completer sits in IDLE and must ignore it.
        for (int c = 0; c < WS + 2; c++) begin
            @(negedge pclk);
            n_cmp++; if (pready !== 1'b0) begin n_bad++; $display("FAIL rstmid_hold[%0d] pready: got %b want 0", c, pready); end
        end
        psel = 1'b0; penable = 1'b0;
        tbl.push_back('{1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 32'h0, 1'b0});
        tbl.push_back('{1'b0, 32'h04, 32'h0, 4'h0, 3'b000, 32'h0, 1'b0});
        tbl.push_back('{1'b0, 32'h00, 32'h0, 4'h0, 3'b000, ID,    1'b0});
        foreach (tbl[i]) begin
            sb.push_back('{tbl[i].exp_d, tbl[i].exp_e});
            apb_xfer(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].p);
            ex = sb.pop_front();
            n_cmp++; if (obs_to)             begin n_bad++; $display("FAIL rstmid_rd[%0d] timeout: no pready", i); end
            n_cmp++; if (obs_waits !== WS)   begin n_bad++; $display("FAIL rstmid_rd[%0d] waits: got %0d want %0d", i, obs_waits, WS); end
            n_cmp++; if (obs_err !== ex.err) begin n_bad++; $display("FAIL rstmid_rd[%0d] pslverr: got %b want %b", i, obs_err, ex.err); end
            n_cmp++; if (obs_rdata !== ex.rdata) begin n_bad++; $display("FAIL rstmid_rd[%0d] prdata: got %h want %h", i, obs_rdata, ex.rdata); end
        end
    endtask

    initial begin
        reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
        test_reset();
        test_write_read();
        test_errors();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1);
    end

endmodule
